// File: rtl/obi_uart_msr_ctrl.sv
// Purpose: Modem Status Register (live + sticky delta bits), modem-status irq, auto-CTS transmit gating FSM.
// Latency: MSR bits and tx grant are registered (1 cycle); irq_msr_o is combinational from registered state.
// Backpressure: tx_grant_o holds the transmitter off while auto flow control is on and CTS is deasserted.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   msr_i            MSR bits from modem stage (3:0 delta events, 7:4 live status)
//   msr_rd_i         bus read strobe for MSR; clears delta bits and the CTS timeout flag next cycle
//   ier_edssi_i      modem-status interrupt enable
//   afe_i            auto flow control enable
//   tx_req_i         transmitter has a character ready (level)
//   tx_done_i        stop bit of the current character complete (pulse)
//   msr_o            MSR read value
//   irq_msr_o        modem-status interrupt request
//   tx_grant_o       transmitter may shift the current character
//   cts_timeout_o    sticky flag: CTS held the transmitter for HoldTimeout cycles
module obi_uart_msr_ctrl #(
    parameter int HoldTimeout = 1024,
    localparam int CntWidth = $clog2(HoldTimeout + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] msr_i,
    input  logic       msr_rd_i,
    input  logic       ier_edssi_i,
    input  logic       afe_i,
    input  logic       tx_req_i,
    input  logic       tx_done_i,
    output logic [7:0] msr_o,
    output logic       irq_msr_o,
    output logic       tx_grant_o,
    output logic       cts_timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam logic [CntWidth-1:0] HoldMax = CntWidth'(HoldTimeout);

    state_e              state_q;
    state_e              state_d;
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_d;
    logic [CntWidth-1:0] cnt_inc;
    logic [7:0]          msr_q;
    logic                timeout_q;
    logic                timeout_set;
    logic                cts_clear;

    // Transmission is allowed when flow control is off or the registered CTS is high.
    assign cts_clear = ~afe_i | msr_q[4];
    assign cnt_inc   = cnt_q + 1'b1;

    // State register plus MSR and timeout flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            msr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Delta bits: a read clears, but an event arriving in the read cycle re-sets,
            // so no event is ever lost.
            msr_q   <= {msr_i[7:4], (msr_q[3:0] & ~{4{msr_rd_i}}) | msr_i[3:0]};
            // Set wins over a simultaneous read-clear.
            timeout_q <= timeout_set | (timeout_q & ~msr_rd_i);
        end
    end

    // Next-state logic. The hold counter is zero everywhere except while waiting in HOLD,
    // so every entry into HOLD starts from zero.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        timeout_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_req_i) begin
                    state_d = cts_clear ? SEND : HOLD;
                end
            end
            HOLD: begin
                if (!tx_req_i) begin
                    state_d = IDLE;
                end else if (cts_clear) begin
                    state_d = SEND;
                end else if (cnt_q != HoldMax) begin
                    cnt_d       = cnt_inc;
                    // Flag only on the step that reaches the limit, not while saturated.
                    timeout_set = (cnt_inc == HoldMax);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            SEND: begin
                // A character in flight always completes; CTS and tx_req_i are not looked at.
                if (tx_done_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs. The grant is decoded from the state register only, so it is a registered level.
    always_comb begin
        tx_grant_o    = (state_q == SEND);
        msr_o         = msr_q;
        cts_timeout_o = timeout_q;
        irq_msr_o     = ier_edssi_i & ((|msr_q[3:0]) | timeout_q);
    end

endmodule

// File: tb/tb_obi_uart_msr_ctrl.sv
module tb_obi_uart_msr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] msr_i;
    logic       msr_rd;
    logic       ier_edssi;
    logic       afe;
    logic       tx_req;
    logic       tx_done;
    logic [7:0] msr_o;
    logic       irq_msr;
    logic       tx_grant;
    logic       cts_timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [7:0] msr;
        logic       irq;
        logic       grant;
        logic       to;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    obi_uart_msr_ctrl #(.HoldTimeout(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .msr_i        (msr_i),
        .msr_rd_i     (msr_rd),
        .ier_edssi_i  (ier_edssi),
        .afe_i        (afe),
        .tx_req_i     (tx_req),
        .tx_done_i    (tx_done),
        .msr_o        (msr_o),
        .irq_msr_o    (irq_msr),
        .tx_grant_o   (tx_grant),
        .cts_timeout_o(cts_timeout)
    );

    task automatic check(input string tag, input string what, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, expv);
        end
    endtask

    // Inputs are already applied; push the expected post-edge outputs, clock once,
    // then pop and compare at the falling edge.
    task automatic step(input string tag, input logic [7:0] e_msr, input logic e_irq,
                        input logic e_grant, input logic e_to);
        exp_t e;
        exp_t got;
        e.tag = tag; e.msr = e_msr; e.irq = e_irq; e.grant = e_grant; e.to = e_to;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = sb_q.pop_front();
        check(got.tag, "msr",   msr_o,                got.msr);
        check(got.tag, "irq",   {7'd0, irq_msr},      {7'd0, got.irq});
        check(got.tag, "grant", {7'd0, tx_grant},     {7'd0, got.grant});
        check(got.tag, "to",    {7'd0, cts_timeout},  {7'd0, got.to});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; msr_i = 8'h00; msr_rd = 1'b0; ier_edssi = 1'b0;
        afe = 1'b0; tx_req = 1'b0; tx_done = 1'b0;
        @(negedge clk);
        step("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Sticky delta and clear-on-read
        ier_edssi = 1'b1;
        msr_i = 8'h01;               step("d_set",  8'h01, 1'b1, 1'b0, 1'b0);
        msr_i = 8'h00;               step("d_hold", 8'h01, 1'b1, 1'b0, 1'b0);
        msr_rd = 1'b1;               step("d_clr",  8'h00, 1'b0, 1'b0, 1'b0);
        msr_rd = 1'b0;

        // Read colliding with a new event keeps the bit
        msr_i = 8'h04;               step("c_set",  8'h04, 1'b1, 1'b0, 1'b0);
        msr_rd = 1'b1;               step("c_coll", 8'h04, 1'b1, 1'b0, 1'b0);
        msr_i = 8'h00;               step("c_clr",  8'h00, 1'b0, 1'b0, 1'b0);
        msr_rd = 1'b0;

        // Status bits follow the input with no stickiness
        msr_i = 8'hA0;               step("st_on",  8'hA0, 1'b0, 1'b0, 1'b0);
        msr_i = 8'h00;               step("st_off", 8'h00, 1'b0, 1'b0, 1'b0);

        // Flow control off: grant one cycle after request, drops after done
        tx_req = 1'b1;               step("g_rise", 8'h00, 1'b0, 1'b1, 1'b0);
        tx_req = 1'b0;               step("g_keep", 8'h00, 1'b0, 1'b1, 1'b0);
        tx_done = 1'b1;              step("g_done", 8'h00, 1'b0, 1'b0, 1'b0);
        tx_done = 1'b1;              step("g_ign",  8'h00, 1'b0, 1'b0, 1'b0);
        tx_done = 1'b0;

        // Flow control on, CTS low: held; CTS rises -> grant two cycles later
        afe = 1'b1; tx_req = 1'b1;   step("h_1",    8'h00, 1'b0, 1'b0, 1'b0);
                                     step("h_2",    8'h00, 1'b0, 1'b0, 1'b0);
        msr_i = 8'h10;               step("h_cts",  8'h10, 1'b0, 1'b0, 1'b0);
                                     step("h_send", 8'h10, 1'b0, 1'b1, 1'b0);
        msr_i = 8'h00;               step("s_drop", 8'h00, 1'b0, 1'b1, 1'b0);
                                     step("s_keep", 8'h00, 1'b0, 1'b1, 1'b0);
        tx_done = 1'b1; tx_req = 1'b0; step("s_done", 8'h00, 1'b0, 1'b0, 1'b0);
        tx_done = 1'b0;

        // Hold timeout with HoldTimeout=8: flag sets on the 8th cycle spent in HOLD
        tx_req = 1'b1;
        for (int i = 0; i < 8; i++) step("to_wait", 8'h00, 1'b0, 1'b0, 1'b0);
                                     step("to_set", 8'h00, 1'b1, 1'b0, 1'b1);
                                     step("to_sat", 8'h00, 1'b1, 1'b0, 1'b1);
        msr_rd = 1'b1;               step("to_clr", 8'h00, 1'b0, 1'b0, 1'b0);
        msr_rd = 1'b0;               step("to_hold", 8'h00, 1'b0, 1'b0, 1'b0);
                                     step("to_nore", 8'h00, 1'b0, 1'b0, 1'b0);

        // Dropping afe while held releases to SEND next cycle
        afe = 1'b0;                  step("afe_rel", 8'h00, 1'b0, 1'b1, 1'b0);

        // Reset during SEND
        msr_i = 8'h21;               step("pre_rst", 8'h21, 1'b1, 1'b1, 1'b0);
        rst = 1'b1; msr_i = 8'h00;   step("rst_send", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;                  step("post_rst", 8'h00, 1'b0, 1'b1, 1'b0);
        tx_done = 1'b1; tx_req = 1'b0; step("end_done", 8'h00, 1'b0, 1'b0, 1'b0);
        tx_done = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
